// File: rtl/router_sync_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : router_sync_n                                                 |
// | Purpose  : Channel synchroniser for the 1xN router. Latches the header   |
// |            destination address, steers the FSM write request to one of  |
// |            NUM_CH output FIFOs, returns the addressed FIFO's full flag,  |
// |            derives per-channel valid-out and runs a per-channel read     |
// |            timeout that emits a one-cycle soft reset pulse.              |
// | Ports    : clock, resetn (async, active low)                             |
// |            detect_add, data_in       - header address capture            |
// |            write_enb_reg             - FSM write request                 |
// |            read_enb, empty, full     - per-channel FIFO/destination side |
// |            vld_out, write_enb        - per-channel valid / write enable  |
// |            fifo_full                 - full flag of addressed FIFO       |
// |            soft_reset                - per-channel timeout pulse         |
// |            addr_err                  - latched address >= NUM_CH         |
// |            timeout_sticky, sticky_clr- sticky timeout status             |
// | Option   : ROUTER_SYNC_TIMEOUT_STATUS_EN builds the sticky status flops; |
// |            without it timeout_sticky is 0 and sticky_clr is ignored.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int TMR_W   = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_sticky,
  input  logic              sticky_clr
);

  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_err;
  logic [NUM_CH-1:0] w_sel;

  // Address register and error flag, both captured on detect_add edges.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_addr_err <= 1'b0;
    end else if (detect_add) begin
      r_addr     <= data_in;
      r_addr_err <= (32'(data_in) >= 32'(NUM_CH));
    end
  end

  assign addr_err = r_addr_err;
  assign vld_out  = ~empty;

  // One-hot decode of the latched address. An out-of-range address decodes
  // to all zeros, which suppresses both the write strobe and the full flag.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_sel
      assign w_sel[i] = (32'(r_addr) == i);
    end
  endgenerate

  assign write_enb = write_enb_reg ? w_sel : '0;
  assign fifo_full = |(full & w_sel);

  // Per-channel read timeout. Channels are fully independent.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [TMR_W-1:0] r_timer;
      logic             r_pulse;
      logic             w_stall;
      logic             w_fire;

      assign w_stall = ~empty[i] & ~read_enb[i];
      assign w_fire  = w_stall & (r_timer == c_TMR_LAST);

      // Timer clears when it fires, so it never needs to wrap.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_timer <= '0;
          r_pulse <= 1'b0;
        end else if (!w_stall) begin
          r_timer <= '0;
          r_pulse <= 1'b0;
        end else if (w_fire) begin
          r_timer <= '0;
          r_pulse <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
          r_pulse <= 1'b0;
        end
      end

      assign soft_reset[i] = r_pulse;

`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
      logic r_sticky;

      // Set has priority over clear on the same edge.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          r_sticky <= 1'b0;
        end else if (w_fire) begin
          r_sticky <= 1'b1;
        end else if (sticky_clr) begin
          r_sticky <= 1'b0;
        end
      end

      assign timeout_sticky[i] = r_sticky;
`else
      assign timeout_sticky[i] = 1'b0;
`endif
    end
  endgenerate

`ifndef ROUTER_SYNC_TIMEOUT_STATUS_EN
  logic w_unused_sticky_clr;
  assign w_unused_sticky_clr = sticky_clr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_sync_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_router_sync_n                                              |
// | Purpose  : Self-checking bench for router_sync_n with a behavioural     |
// |            model (address latch + consecutive-stall run lengths).        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_router_sync_n;
  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;
  localparam int TMR_W   = 5;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              detect_add = 1'b0;
  logic [ADDR_W-1:0] data_in = '0;
  logic              write_enb_reg = 1'b0;
  logic [NUM_CH-1:0] read_enb = '0;
  logic [NUM_CH-1:0] empty = '1;
  logic [NUM_CH-1:0] full = '0;
  logic              sticky_clr = 1'b0;
  logic [NUM_CH-1:0] vld_out, write_enb, soft_reset, timeout_sticky;
  logic              fifo_full, addr_err;

  int n_vec = 0;
  int n_err = 0;

  router_sync_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
    .vld_out(vld_out), .write_enb(write_enb), .fifo_full(fifo_full),
    .soft_reset(soft_reset), .addr_err(addr_err), .timeout_sticky(timeout_sticky),
    .sticky_clr(sticky_clr)
  );

  always #5 clock = ~clock;

  // Reference model: latched address plus, per channel, the length of the
  // current run of consecutive valid-and-unread edges. A pulse is due after
  // every TIMEOUT-th edge of an unbroken run.
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_err = 1'b0;
  int                m_run [NUM_CH];
  logic [NUM_CH-1:0] m_soft = '0;
  logic [NUM_CH-1:0] m_sticky = '0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_addr <= '0;
      m_err <= 1'b0;
      m_soft <= '0;
      m_sticky <= '0;
      for (int i = 0; i < NUM_CH; i++) m_run[i] <= 0;
    end else begin
      if (detect_add) begin
        m_addr <= data_in;
        m_err <= (int'(data_in) >= NUM_CH);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!empty[i] && !read_enb[i]) begin
          m_run[i] <= m_run[i] + 1;
          m_soft[i] <= (((m_run[i] + 1) % TIMEOUT) == 0);
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
          if (((m_run[i] + 1) % TIMEOUT) == 0) m_sticky[i] <= 1'b1;
          else if (sticky_clr) m_sticky[i] <= 1'b0;
`endif
        end else begin
          m_run[i] <= 0;
          m_soft[i] <= 1'b0;
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
          if (sticky_clr) m_sticky[i] <= 1'b0;
`endif
        end
      end
    end
  end

  function automatic logic [NUM_CH-1:0] exp_wen(input logic [ADDR_W-1:0] a, input logic we);
    exp_wen = '0;
    if (we && int'(a) < NUM_CH) exp_wen[a] = 1'b1;
  endfunction

  function automatic logic exp_ff(input logic [ADDR_W-1:0] a, input logic [NUM_CH-1:0] f);
    exp_ff = (int'(a) < NUM_CH) ? f[a] : 1'b0;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    empty = NUM_CH'($urandom);
    full = NUM_CH'($urandom);
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++; if (write_enb !== '0) begin n_err++; $display("FAIL reset_wen: got %b want %b", write_enb, 3'b000); end
    n_vec++; if (soft_reset !== '0) begin n_err++; $display("FAIL reset_soft: got %b want %b", soft_reset, 3'b000); end
    n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_aerr: got %b want 0", addr_err); end
    n_vec++; if (timeout_sticky !== '0) begin n_err++; $display("FAIL reset_sticky: got %b want 000", timeout_sticky); end
    n_vec++; if (vld_out !== ~empty) begin n_err++; $display("FAIL reset_vld: got %b want %b", vld_out, ~empty); end
    n_vec++; if (fifo_full !== full[0]) begin n_err++; $display("FAIL reset_ffull: got %b want %b", fifo_full, full[0]); end
    empty = '1;
    full = '0;
    resetn = 1'b1;
  endtask

  task automatic test_addr();
    @(negedge clock); detect_add = 1'b1; data_in = 2'd2;
    @(negedge clock); detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100; #1;
    n_vec++; if (write_enb !== 3'b100) begin n_err++; $display("FAIL addr2_wen: got %b want 100", write_enb); end
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL addr2_ffull: got %b want 1", fifo_full); end
    // Same-cycle capture and write must still use the old address.
    detect_add = 1'b1; data_in = 2'd3; #1;
    n_vec++; if (write_enb !== 3'b100) begin n_err++; $display("FAIL addr_samecyc_wen: got %b want 100", write_enb); end
    @(negedge clock); detect_add = 1'b0; full = 3'b111; #1;
    n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL addr3_aerr: got %b want 1", addr_err); end
    n_vec++; if (write_enb !== 3'b000) begin n_err++; $display("FAIL addr3_wen: got %b want 000", write_enb); end
    n_vec++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL addr3_ffull: got %b want 0", fifo_full); end
    detect_add = 1'b1; data_in = 2'd1;
    @(negedge clock); detect_add = 1'b0; full = 3'b010; #1;
    n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL addr1_aerr: got %b want 0", addr_err); end
    n_vec++; if (write_enb !== 3'b010) begin n_err++; $display("FAIL addr1_wen: got %b want 010", write_enb); end
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL addr1_ffull: got %b want 1", fifo_full); end
    write_enb_reg = 1'b0;
    full = '0;
  endtask

  task automatic test_timeout();
    @(negedge clock); empty = 3'b110; read_enb = '0;
    for (int cyc = 1; cyc <= 65; cyc++) begin
      @(negedge clock);
      n_vec++;
      if (soft_reset !== ((cyc == 30 || cyc == 60) ? 3'b001 : 3'b000)) begin
        n_err++; $display("FAIL timeout_ch0 cyc%0d: got %b want %b", cyc, soft_reset, (cyc == 30 || cyc == 60) ? 3'b001 : 3'b000);
      end
    end
    empty = '1;
    @(negedge clock);
  endtask

  task automatic test_read_abort();
    empty = 3'b110;
    for (int cyc = 1; cyc <= 62; cyc++) begin
      read_enb = (cyc == 30) ? 3'b001 : 3'b000;
      @(negedge clock);
      n_vec++;
      if (soft_reset[0] !== (cyc == 60)) begin
        n_err++; $display("FAIL read_abort cyc%0d: got %b want %b", cyc, soft_reset[0], (cyc == 60));
      end
    end
    read_enb = '0;
    empty = '1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    empty = 3'b001;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clock);
      n_vec++; if (soft_reset !== '0) begin n_err++; $display("FAIL midrst_pre cyc%0d: got %b want 000", cyc, soft_reset); end
    end
    #2 resetn = 1'b0; #1;
    n_vec++; if (soft_reset !== '0) begin n_err++; $display("FAIL midrst_async: got %b want 000", soft_reset); end
    @(negedge clock); resetn = 1'b1;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clock);
      n_vec++;
      if (soft_reset !== ((cyc == 30) ? 3'b110 : 3'b000)) begin
        n_err++; $display("FAIL midrst_post cyc%0d: got %b want %b", cyc, soft_reset, (cyc == 30) ? 3'b110 : 3'b000);
      end
    end
    empty = '1;
    @(negedge clock);
  endtask

  task automatic test_sticky();
    logic [NUM_CH-1:0] want;
    resetn = 1'b0; #1; resetn = 1'b1;
    empty = 3'b101;
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    for (int cyc = 1; cyc <= 61; cyc++) begin
      sticky_clr = (cyc == 60 || cyc == 61);
      @(negedge clock);
      want = (cyc >= 30 && cyc <= 60) ? 3'b010 : 3'b000;
      n_vec++;
      if (timeout_sticky !== want) begin
        n_err++; $display("FAIL sticky cyc%0d: got %b want %b", cyc, timeout_sticky, want);
      end
    end
`else
    for (int cyc = 1; cyc <= 40; cyc++) begin
      sticky_clr = $urandom_range(0, 1) == 1;
      @(negedge clock);
      want = (cyc == 30) ? 3'b010 : 3'b000;
      n_vec++;
      if (timeout_sticky !== '0 || soft_reset !== want) begin
        n_err++; $display("FAIL sticky_off cyc%0d: got %b/%b want 000/%b", cyc, timeout_sticky, soft_reset, want);
      end
    end
`endif
    sticky_clr = 1'b0;
    empty = '1;
    @(negedge clock);
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 800; n++) begin
      @(negedge clock);
      resetn = ($urandom_range(0, 299) != 0);
      detect_add = ($urandom_range(0, 3) == 0);
      data_in = ADDR_W'($urandom);
      write_enb_reg = $urandom_range(0, 1) == 1;
      full = NUM_CH'($urandom);
      sticky_clr = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 49) == 0) empty[i] = ~empty[i];
        read_enb[i] = ($urandom_range(0, 63) == 0);
      end
      #1;
      bad = 0;
      if (write_enb !== exp_wen(m_addr, write_enb_reg)) bad++;
      if (fifo_full !== exp_ff(m_addr, full)) bad++;
      if (vld_out !== ~empty) bad++;
      if (addr_err !== m_err) bad++;
      if (soft_reset !== m_soft) bad++;
      if (timeout_sticky !== m_sticky) bad++;
      n_vec++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL random n%0d: got wen=%b ff=%b vld=%b aerr=%b soft=%b stk=%b want wen=%b ff=%b vld=%b aerr=%b soft=%b stk=%b",
                 n, write_enb, fifo_full, vld_out, addr_err, soft_reset, timeout_sticky,
                 exp_wen(m_addr, write_enb_reg), exp_ff(m_addr, full), ~empty, m_err, m_soft, m_sticky);
      end
    end
    resetn = 1'b1;
    detect_add = 1'b0;
    write_enb_reg = 1'b0;
    sticky_clr = 1'b0;
    read_enb = '0;
    empty = '1;
  endtask

  initial begin
    test_reset();
    test_addr();
    test_timeout();
    test_read_abort();
    test_reset_mid();
    test_sticky();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/router_sync_n.md
# router_sync_n

Parametrised channel synchroniser for the 1xN router. It latches the destination address from the header, steers the write enable to one of NUM_CH output FIFOs, and muxes the selected FIFO's full flag back to the FSM. It derives per-channel valid-out from FIFO empty, and runs a per-channel read-timeout counter that issues a one-cycle soft reset when a channel sits unread. It sits between the router FSM and the NUM_CH output FIFOs.

## Interface
- NUM_CH, 3, number of output channels (1..8)
- ADDR_W, 2, header address width; 2**ADDR_W >= NUM_CH
- TIMEOUT, 30, consecutive valid-and-unread cycles before soft reset (2..2**TMR_W)
- TMR_W, 5, timeout counter width

Ports:
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- detect_add  in  1  latch data_in as destination address
- data_in  in  ADDR_W  address field of header byte
- write_enb_reg  in  1  FSM write request
- read_enb  in  NUM_CH  per-channel read enable from destination
- empty  in  NUM_CH  per-channel FIFO empty
- full  in  NUM_CH  per-channel FIFO full
- vld_out  out  NUM_CH  per-channel data valid
- write_enb  out  NUM_CH  one-hot FIFO write enable
- fifo_full  out  1  full flag of addressed FIFO
- soft_reset  out  NUM_CH  per-channel timeout reset pulse
- addr_err  out  1  latched address >= NUM_CH
- timeout_sticky  out  NUM_CH  sticky timeout status (see Configuration)
- sticky_clr  in  1  clears timeout_sticky

## Operation
- Address register: cleared to 0 on reset; loads data_in on any edge with detect_add=1; otherwise holds.
- addr_err: registered; updated on detect_add edges to (data_in >= NUM_CH); reset 0.
- write_enb (combinational): bit[addr]=1 iff write_enb_reg=1 and addr < NUM_CH; else all zero.
- fifo_full (combinational): full[addr] if addr < NUM_CH; else 0.
- vld_out[i] = ~empty[i], combinational.
- Timeout, per channel i, independent:
  - If vld_out[i]=0 or read_enb[i]=1: timer[i] cleared to 0, soft_reset[i]=0.
  - Else, if timer[i]==TIMEOUT-1: timer[i] cleared to 0, soft_reset[i]=1.
  - Else: timer[i] increments, soft_reset[i]=0.
- soft_reset[i] is a single-cycle pulse. It re-fires every TIMEOUT cycles while the channel stays valid and unread.
- Any read, or the FIFO going empty, restarts the count from 0. There is no partial carry-over.
- Timer arithmetic is TMR_W bits unsigned and never wraps, because it clears at TIMEOUT-1.

## Timing
- Reset values: write_enb=0, fifo_full=full[0], vld_out=~empty, soft_reset=0, addr_err=0, timeout_sticky=0, all timers 0.
- Address latch latency: 1 cycle.
- A detect_add and write_enb_reg asserted in the same cycle use the previously latched address for that cycle.
- soft_reset[i] rises after the TIMEOUT-th consecutive edge that samples vld_out[i]=1 and read_enb[i]=0. It falls on the next edge.
- read_enb[i]=1 on the edge where timer[i]==TIMEOUT-1 gives no pulse; the timer clears.
- resetn asserted mid-count clears timers, pulses and status immediately (asynchronously). Counting resumes from 0 after release.
- Channels never interact. Simultaneous timeouts on several channels pulse together.

## Configuration
- ROUTER_SYNC_TIMEOUT_STATUS_EN defined:
  - timeout_sticky[i] sets on the edge soft_reset[i] is set.
  - It clears on an edge with sticky_clr=1.
  - If set and clear occur on the same edge, set wins.
- Not defined: timeout_sticky is tied to 0, sticky_clr is ignored, and no status flops are built.

## Test plan
- Reset then detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100 one cycle after latch; full[2]=1 -> fifo_full=1.
- data_in=3 with NUM_CH=3 -> addr_err=1 next cycle; write_enb_reg=1 -> write_enb=0, fifo_full=0. Then latch data_in=1 -> addr_err=0.
- empty[0]=0, read_enb[0]=0 held, TIMEOUT=30 -> soft_reset[0] high exactly in cycle 31 for 1 cycle. Held further -> next pulse 30 cycles later.
- Same as above but read_enb[0]=1 at cycle 29 -> no pulse; a fresh 30-cycle count starts after read_enb drops.
- Channels 1 and 2 both stalled, resetn pulsed low at cycle 15 -> no soft_reset. Pulses occur 30 cycles after release.
- With ROUTER_SYNC_TIMEOUT_STATUS_EN: timeout on ch1 -> timeout_sticky=3'b010 held. sticky_clr coincident with a ch1 pulse -> stays set. A lone sticky_clr -> 0. Without the macro -> always 0.
